// File: rtl/uart_pkg.sv
// Shared UART types and counter-width helpers for the TX frame path and the FIFO.
// ST_BREAK is only reachable when UART_TX_BREAK_EN is defined.
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_EVEN = 2'd1,
    PAR_ODD  = 2'd2
  } parity_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_BREAK  = 3'd5
  } tx_state_e;

  localparam int STOP_CNT_W = 1;

  function automatic int tick_cnt_w(input int sampling);
    return (sampling > 2) ? $clog2(sampling) : 1;
  endfunction

  function automatic int bit_cnt_w(input int data_width);
    return $clog2(data_width + 1);
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous FIFO with registered full/empty/count; a push while full is dropped.
// Shared by the UART TX and RX paths.
module uart_tx_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          i_push,
  input  logic [DATA_WIDTH-1:0]         i_data,
  input  logic                          i_pop,
  output logic [DATA_WIDTH-1:0]         o_data,
  output logic                          o_full,
  output logic                          o_empty,
  output logic [$clog2(FIFO_DEPTH):0]   o_count
);

  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int CNT_W = AW + 1;

  logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]         r_wr_ptr;
  logic [AW-1:0]         r_rd_ptr;
  logic [CNT_W-1:0]      r_count;
  logic                  r_full;
  logic                  r_empty;
  logic                  w_do_push;
  logic                  w_do_pop;
  logic [CNT_W-1:0]      w_count_next;

  assign w_do_push    = i_push && !r_full;
  assign w_do_pop     = i_pop && !r_empty;
  assign w_count_next = r_count + {{AW{1'b0}}, w_do_push} - {{AW{1'b0}}, w_do_pop};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= w_count_next;
      r_full  <= (w_count_next == CNT_W'(FIFO_DEPTH));
      r_empty <= (w_count_next == '0);
    end
  end

  // Storage is not reset; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

  assign o_data  = r_mem[r_rd_ptr];
  assign o_full  = r_full;
  assign o_empty = r_empty;
  assign o_count = r_count;

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmitter: input FIFO, per-frame parity/stop latching, b_tick-timed bits.
// Optional line break generation is enabled with the UART_TX_BREAK_EN macro.
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int SAMPLING   = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          b_tick,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic [DATA_WIDTH-1:0]         s_data,
  input  logic [1:0]                    cfg_parity,
  input  logic                          cfg_stop2,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          tx_busy,
  output logic                          tx
`ifdef UART_TX_BREAK_EN
  ,
  input  logic                          brk
`endif
);

  localparam int TICK_W = tick_cnt_w(SAMPLING);
  localparam int BIT_W  = bit_cnt_w(DATA_WIDTH);

  tx_state_e             r_state;
  tx_state_e             w_state_next;
  logic [TICK_W-1:0]     r_tick;
  logic [BIT_W-1:0]      r_bit_cnt;
  logic [STOP_CNT_W-1:0] r_stop_cnt;
  logic [DATA_WIDTH-1:0] r_shift;
  logic                  r_par_acc;
  parity_e               r_par_cfg;
  logic                  r_stop2;
  logic                  r_tx;
  logic                  r_busy;
  logic                  w_tx_next;
  logic                  w_busy_next;
  logic                  w_pop;
  logic                  w_counting;
  logic                  w_bit_end;
  logic                  w_fifo_full;
  logic                  w_fifo_empty;
  logic [DATA_WIDTH-1:0] w_fifo_data;

  uart_tx_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (s_valid),
    .i_data  (s_data),
    .i_pop   (w_pop),
    .o_data  (w_fifo_data),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_count (fifo_count)
  );

  assign s_ready    = !w_fifo_full;
  assign w_counting = (r_state == ST_START) || (r_state == ST_DATA) ||
                      (r_state == ST_PARITY) || (r_state == ST_STOP);
  assign w_bit_end  = w_counting && b_tick && (r_tick == TICK_W'(SAMPLING - 1));

  // State register plus the datapath that moves with it.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_tick     <= '0;
      r_bit_cnt  <= '0;
      r_stop_cnt <= '0;
      r_shift    <= '0;
      r_par_acc  <= 1'b0;
      r_par_cfg  <= PAR_NONE;
      r_stop2    <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_pop) begin
        r_shift    <= w_fifo_data;
        r_par_cfg  <= (cfg_parity == 2'd3) ? PAR_NONE : parity_e'(cfg_parity);
        r_stop2    <= cfg_stop2;
        r_par_acc  <= 1'b0;
        r_tick     <= '0;
        r_bit_cnt  <= '0;
        r_stop_cnt <= '0;
      end else if (w_counting && b_tick) begin
        r_tick <= w_bit_end ? '0 : r_tick + TICK_W'(1);
        if (w_bit_end && r_state == ST_DATA) begin
          r_par_acc <= r_par_acc ^ r_shift[0];
          r_shift   <= r_shift >> 1;
          r_bit_cnt <= r_bit_cnt + BIT_W'(1);
        end
        if (w_bit_end && r_state == ST_STOP) begin
          r_stop_cnt <= STOP_CNT_W'(r_stop2 && (r_stop_cnt == '0));
        end
      end
`ifdef UART_TX_BREAK_EN
      // The post-break recovery period is always a single stop bit.
      if (r_state == ST_BREAK) r_stop2 <= 1'b0;
`endif
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_pop        = 1'b0;
    case (r_state)
      ST_IDLE: begin
`ifdef UART_TX_BREAK_EN
        if (brk) w_state_next = ST_BREAK;
        else
`endif
        if (!w_fifo_empty) begin
          w_state_next = ST_START;
          w_pop        = 1'b1;
        end
      end
      ST_START:  if (w_bit_end) w_state_next = ST_DATA;
      ST_DATA: begin
        if (w_bit_end && r_bit_cnt == BIT_W'(DATA_WIDTH - 1)) begin
          w_state_next = (r_par_cfg == PAR_NONE) ? ST_STOP : ST_PARITY;
        end
      end
      ST_PARITY: if (w_bit_end) w_state_next = ST_STOP;
      ST_STOP: begin
        if (w_bit_end && (!r_stop2 || r_stop_cnt != '0)) begin
          if (!w_fifo_empty) begin
            w_state_next = ST_START;
            w_pop        = 1'b1;
          end else begin
            w_state_next = ST_IDLE;
          end
        end
      end
`ifdef UART_TX_BREAK_EN
      ST_BREAK:  if (!brk) w_state_next = ST_STOP;
`endif
      default:   w_state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_tx_next   = 1'b1;
    w_busy_next = 1'b1;
    case (r_state)
      ST_IDLE:   w_busy_next = 1'b0;
      ST_START:  w_tx_next   = 1'b0;
      ST_DATA:   w_tx_next   = r_shift[0];
      ST_PARITY: w_tx_next   = (r_par_cfg == PAR_ODD) ? ~r_par_acc : r_par_acc;
      ST_STOP:   w_tx_next   = 1'b1;
      ST_BREAK:  w_tx_next   = 1'b0;
      default: begin
        w_tx_next   = 1'b1;
        w_busy_next = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_tx   <= 1'b1;
      r_busy <= 1'b0;
    end else begin
      r_tx   <= w_tx_next;
      r_busy <= w_busy_next;
    end
  end

  assign tx      = r_tx;
  assign tx_busy = r_busy;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Testbench for uart_tx_frame: random words checked against a bit-list frame model.
// Break scenarios are included when UART_TX_BREAK_EN is defined.
module tb_uart_tx_frame;

  localparam int DW    = 8;
  localparam int SAMP  = 4;
  localparam int DEPTH = 4;

  logic          clk;
  logic          reset;
  logic          b_tick;
  logic          s_valid;
  logic          s_ready;
  logic [DW-1:0] s_data;
  logic [1:0]    cfg_parity;
  logic          cfg_stop2;
  logic [2:0]    fifo_count;
  logic          tx_busy;
  logic          tx;
`ifdef UART_TX_BREAK_EN
  logic          brk;
`endif

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] exp_q[$];
  bit   mon_en = 1'b0;
  int   busy_gap = 0;

  uart_tx_frame #(
    .DATA_WIDTH (DW),
    .SAMPLING   (SAMP),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .b_tick     (b_tick),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .cfg_parity (cfg_parity),
    .cfg_stop2  (cfg_stop2),
    .fifo_count (fifo_count),
    .tx_busy    (tx_busy),
    .tx         (tx)
`ifdef UART_TX_BREAK_EN
    ,
    .brk        (brk)
`endif
  );

  // Clock and continuous busy monitor
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (mon_en && !tx_busy) busy_gap++;
  end

  // Reference model: frame as a list of line bits, each held for SAMP ticks.
  function automatic void build_frame(input logic [DW-1:0] d, input logic [1:0] par,
                                      input bit stop2, output logic [63:0] v, output int n);
    bit bq[$];
    bq.push_back(1'b0);
    for (int k = 0; k < DW; k++) bq.push_back(d[k]);
    if (par == 2'd1) bq.push_back(^d);
    else if (par == 2'd2) bq.push_back(~^d);
    bq.push_back(1'b1);
    if (stop2) bq.push_back(1'b1);
    v = '0;
    n = 0;
    foreach (bq[b]) begin
      for (int s = 0; s < SAMP; s++) begin
        v[n] = bq[b];
        n++;
      end
    end
  endfunction

  // Driver tasks
  task automatic push_word(input logic [DW-1:0] d, output bit acc);
    @(negedge clk);
    s_valid = 1'b1;
    s_data  = d;
    acc     = s_ready;
    if (acc) exp_q.push_back(d);
    @(posedge clk);
    #1 s_valid = 1'b0;
  endtask

  task automatic run_ticks(input int n, output logic [63:0] obs, output bit busy_all);
    obs      = '0;
    busy_all = 1'b1;
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      @(negedge clk);
      b_tick = 1'b1;
      obs[i] = tx;
      if (tx_busy !== 1'b1) busy_all = 1'b0;
      @(negedge clk);
      b_tick = 1'b0;
    end
  endtask

  // Pops the next expected word and checks its whole frame on the line.
  task automatic check_frame(input string name, input logic [1:0] par, input bit stop2);
    logic [63:0] exp_v, obs_v;
    int n;
    bit busy_all;
    logic [DW-1:0] d;
    d = exp_q.pop_front();
    build_frame(d, par, stop2, exp_v, n);
    run_ticks(n, obs_v, busy_all);
    checks++;
    if (obs_v !== exp_v) begin
      errors++;
      $display("FAIL %s frame word=%h: tx samples got %h expected %h", name, d, obs_v, exp_v);
    end
    checks++;
    if (busy_all !== 1'b1) begin
      errors++;
      $display("FAIL %s busy: tx_busy low during frame got 0 expected 1", name);
    end
  endtask

  task automatic check_idle(input string name);
    repeat (2) @(negedge clk);
    checks++;
    if (tx_busy !== 1'b0 || tx !== 1'b1) begin
      errors++;
      $display("FAIL %s idle: tx_busy=%b tx=%b expected 0 1", name, tx_busy, tx);
    end
  endtask

  task automatic check_reset_state(input string name);
    checks++;
    if (tx !== 1'b1 || tx_busy !== 1'b0 || fifo_count !== 3'd0 || s_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s: tx=%b busy=%b count=%0d ready=%b expected 1 0 0 1",
               name, tx, tx_busy, fifo_count, s_ready);
    end
  endtask

  // Scenarios
  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_state("reset_asserted");
    reset = 1'b0;
    @(negedge clk);
    check_reset_state("reset_released");
  endtask

  task automatic test_basic();
    bit acc;
    cfg_parity = 2'd0;
    cfg_stop2  = 1'b0;
    push_word(8'hA5, acc);
    repeat (3) @(negedge clk);
    check_frame("basic_a5", 2'd0, 1'b0);
    check_idle("basic_a5");
  endtask

  task automatic test_parity();
    bit acc;
    for (int p = 1; p <= 2; p++) begin
      cfg_parity = 2'(p);
      cfg_stop2  = 1'b0;
      push_word(8'h03, acc);
      repeat (3) @(negedge clk);
      check_frame((p == 1) ? "parity_even" : "parity_odd", 2'(p), 1'b0);
      check_idle("parity");
    end
  endtask

  task automatic test_random();
    bit acc;
    logic [1:0] par;
    bit st2;
    for (int i = 0; i < 8; i++) begin
      par = 2'($urandom_range(0, 3));
      st2 = 1'($urandom_range(0, 1));
      cfg_parity = par;
      cfg_stop2  = st2;
      push_word(DW'($urandom_range(0, 255)), acc);
      repeat (3) @(negedge clk);
      check_frame("random", par, st2);
      check_idle("random");
    end
  endtask

  task automatic test_back_to_back();
    bit acc;
    int n_acc = 0;
    bit last_acc;
    cfg_parity = 2'd1;
    cfg_stop2  = 1'b0;
    for (int i = 0; i < 6; i++) begin
      push_word(DW'($urandom_range(0, 255)), acc);
      if (acc) n_acc++;
      last_acc = acc;
    end
    @(negedge clk);
    checks++;
    if (n_acc != 5 || last_acc !== 1'b0) begin
      errors++;
      $display("FAIL b2b accepted: got %0d (sixth=%b) expected 5 (sixth=0)", n_acc, last_acc);
    end
    checks++;
    if (s_ready !== 1'b0 || fifo_count !== 3'd4) begin
      errors++;
      $display("FAIL b2b full: ready=%b count=%0d expected 0 4", s_ready, fifo_count);
    end
    busy_gap = 0;
    mon_en   = 1'b1;
    for (int f = 0; f < 5; f++) check_frame("b2b", 2'd1, 1'b0);
    mon_en = 1'b0;
    checks++;
    if (busy_gap != 0) begin
      errors++;
      $display("FAIL b2b busy_gap: tx_busy low for %0d cycles expected 0", busy_gap);
    end
    check_idle("b2b");
  endtask

  task automatic test_stop2();
    bit acc;
    cfg_parity = 2'd0;
    cfg_stop2  = 1'b1;
    push_word(8'h5C, acc);
    push_word(8'hC3, acc);
    cfg_stop2 = 1'b0;
    repeat (3) @(negedge clk);
    check_frame("stop2_latched", 2'd0, 1'b1);
    check_frame("stop2_next", 2'd0, 1'b0);
    check_idle("stop2");
  endtask

  task automatic test_reset_mid();
    bit acc;
    logic [63:0] exp_v, obs_v;
    int n;
    bit busy_all;
    cfg_parity = 2'd0;
    cfg_stop2  = 1'b0;
    push_word(8'h96, acc);
    push_word(8'h7E, acc);
    repeat (3) @(negedge clk);
    build_frame(8'h96, 2'd0, 1'b0, exp_v, n);
    run_ticks(4 * SAMP - 2 + SAMP, obs_v, busy_all);
    checks++;
    if (obs_v[17:0] !== exp_v[17:0]) begin
      errors++;
      $display("FAIL reset_mid prefix: got %h expected %h", obs_v[17:0], exp_v[17:0]);
    end
    reset = 1'b1;
    @(negedge clk);
    check_reset_state("reset_mid");
    reset = 1'b0;
    exp_q.delete();
    push_word(8'h2B, acc);
    repeat (3) @(negedge clk);
    check_frame("after_reset", 2'd0, 1'b0);
    check_idle("after_reset");
  endtask

`ifdef UART_TX_BREAK_EN
  task automatic test_break();
    bit acc;
    int bad = 0;
    logic [63:0] exp_v, obs_v;
    int n;
    bit busy_all;
    cfg_parity = 2'd2;
    cfg_stop2  = 1'b0;
    @(negedge clk);
    brk = 1'b1;
    repeat (3) @(negedge clk);
    push_word(8'hE1, acc);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      b_tick = 1'($urandom_range(0, 1));
      if (tx !== 1'b0 || tx_busy !== 1'b1 || fifo_count !== 3'd1) bad++;
    end
    b_tick = 1'b0;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL break_hold: %0d bad cycles (tx/busy/count) expected 0", bad);
    end
    @(negedge clk);
    brk = 1'b0;
    repeat (3) @(negedge clk);
    build_frame(exp_q.pop_front(), 2'd2, 1'b0, exp_v, n);
    exp_v = (exp_v << SAMP) | 64'(SAMP'('1));
    run_ticks(n + SAMP, obs_v, busy_all);
    checks++;
    if (obs_v !== exp_v) begin
      errors++;
      $display("FAIL break_release: tx samples got %h expected %h", obs_v, exp_v);
    end
    check_idle("break");
  endtask
`endif

  initial begin
    reset      = 1'b1;
    b_tick     = 1'b0;
    s_valid    = 1'b0;
    s_data     = '0;
    cfg_parity = 2'd0;
    cfg_stop2  = 1'b0;
`ifdef UART_TX_BREAK_EN
    brk        = 1'b0;
`endif
    test_reset();
    test_basic();
    test_parity();
    test_random();
    test_back_to_back();
    test_stop2();
    test_reset_mid();
`ifdef UART_TX_BREAK_EN
    test_break();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_frame.md
Name: uart_tx_frame

Overview:
- Parametrised UART transmitter with an input FIFO and per-frame configuration.
- Supported frame options: data width, parity (none/even/odd) and 1 or 2 stop bits.
- Sits between the pixel/command packetiser (valid/ready source) and the tx pin.
- Shares the b_tick oversampling generator (SAMPLING ticks per bit) used by the UART RX path.

Parameters:
- DATA_WIDTH, 8, payload bits per frame (5..9), sent LSB first.
- SAMPLING, 16, b_tick pulses per bit period (>=2).
- FIFO_DEPTH, 4, entries in the input FIFO; power of two, >=2.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- b_tick  in  1  single-cycle oversample strobe
- s_valid  in  1  input word valid
- s_ready  out  1  FIFO can accept (not full)
- s_data  in  DATA_WIDTH  input word
- cfg_parity  in  2  0=none, 1=even, 2=odd, 3=reserved (treated as none)
- cfg_stop2  in  1  1 = two stop bits
- fifo_count  out  $clog2(FIFO_DEPTH)+1  words held in the FIFO
- tx_busy  out  1  frame in progress (START..STOP)
- tx  out  1  serial line, idle high

Behaviour:
- One clock domain: clk. Reset is synchronous and active-high on reset.
- Reset: tx=1, tx_busy=0, fifo_count=0, s_ready=1, FSM=IDLE, all counters 0.
- Reset mid-frame aborts the frame. tx returns high on the cycle after reset is sampled. FIFO contents are discarded.
- Input handshake: a word is accepted on a cycle with s_valid && s_ready.
  - s_ready = !full, registered from the count.
  - Push and pop in the same cycle are legal. A push while full is ignored, and the count is unchanged.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE, FIFO non-empty:
  - pop the head word into the shift register;
  - latch cfg_parity and cfg_stop2 for the frame;
  - clear the parity accumulator;
  - go to START.
  - Config changes mid-frame have no effect until the next pop.
- tx and tx_busy are registered and follow the state one cycle later. The first START cycle drives tx=0 and tx_busy=1 on the next clk edge.
- Bit timing:
  - Each bit lasts exactly SAMPLING b_ticks.
  - The tick counter advances only on b_tick and wraps SAMPLING-1 -> 0 at each bit boundary.
  - Ticks arriving in IDLE are ignored.
- START -> DATA after SAMPLING ticks.
- DATA:
  - tx = shift[0];
  - at each bit boundary, XOR shift[0] into parity, shift right, increment bit_cnt.
  - After DATA_WIDTH bits, go to PARITY if the latched parity is 1 or 2, else to STOP.
- PARITY: tx = acc for even, ~acc for odd. Lasts one bit period.
- STOP:
  - tx=1 for SAMPLING ticks, or 2*SAMPLING ticks if stop2 was latched.
  - Then go to IDLE, or straight to START if the FIFO is non-empty (back-to-back pop, no idle bit).
  - tx_busy stays 1 across back-to-back frames and drops only when entering IDLE.
- Frame length in ticks = SAMPLING*(1+DATA_WIDTH+P+S), where P in {0,1} and S in {1,2}.
- Counter widths: tick counter $clog2(SAMPLING), bit counter $clog2(DATA_WIDTH+1), stop counter 1 bit. No overflow is possible by construction.

Optional Feature:
- Macro: UART_TX_BREAK_EN.
- Defined:
  - Adds input port brk (1 bit).
  - brk sampled high in IDLE forces tx=0 and tx_busy=1 for as long as brk stays high; FIFO pops are suppressed.
  - On release, the FSM spends one full stop period (tx=1, SAMPLING ticks) before the next pop.
  - brk asserted mid-frame is ignored until IDLE.
- Undefined: no brk port; behaviour exactly as above.

Decomposition:
- Package uart_pkg holds:
  - parity_e enum (PAR_NONE=0, PAR_EVEN=1, PAR_ODD=2);
  - tx_state_e enum;
  - localparam helpers for the counter widths.
- Sub-module uart_tx_fifo (parameters DATA_WIDTH, FIFO_DEPTH; ports push/pop/full/empty/count) is natural and reused by the RX side.
- The FSM and shifter stay in uart_tx_frame.

Test Plan:
- SAMPLING=4, word 8'hA5, no parity, 1 stop -> tx = 0,1,0,1,0,0,1,0,1,1 bits, each exactly 4 b_ticks; tx_busy high 40 ticks; then tx_busy=0.
- 8'h03 with even parity -> parity bit 0; same word with odd parity -> parity bit 1; frame = 11 bits.
- Push 5 words (FIFO_DEPTH=4) with no b_tick:
  - first word popped immediately;
  - s_ready low after 5th accepted (4 stored, count=4), 6th push ignored;
  - all 5 frames sent back-to-back with no idle gap and tx_busy continuously 1.
- cfg_stop2=1 latched, then cfg_stop2 toggled to 0 mid-frame -> the STOP state of that frame still lasts 2*SAMPLING ticks; the next frame uses 1 stop bit.
- Assert reset during DATA bit 3 -> next cycle tx=1, tx_busy=0, fifo_count=0, s_ready=1; a subsequent word transmits cleanly.
- With UART_TX_BREAK_EN:
  - brk high for 100 cycles in IDLE with 1 word queued -> tx=0 throughout and no pop;
  - after release, tx=1 for SAMPLING ticks, then the queued frame starts.
